// File: rtl/rf_write_scheduler.sv
// Arbitrates the register file's single write port between pipeline writeback and a buffered
// long-latency result stream; optional busy-bit scoreboard enabled by RF_SCOREBOARD_EN.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module rf_write_scheduler #(
  parameter int LL_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_we_i,
  input  logic [`REG_ADDR_WIDTH-1:0] wb_rd_addr_i,
  input  logic [`DATA_WIDTH-1:0]     wb_rd_data_i,
  output logic                       wb_hold_o,
  input  logic                       ll_valid_i,
  output logic                       ll_ready_o,
  input  logic [`REG_ADDR_WIDTH-1:0] ll_rd_addr_i,
  input  logic [`DATA_WIDTH-1:0]     ll_rd_data_i,
  output logic                       rf_we_o,
  output logic [`REG_ADDR_WIDTH-1:0] rf_rd_addr_o,
  output logic [`DATA_WIDTH-1:0]     rf_rd_data_o,
  input  logic                       issue_i,
  input  logic [`REG_ADDR_WIDTH-1:0] issue_rd_i,
  input  logic [`REG_ADDR_WIDTH-1:0] dec_rs1_i,
  input  logic [`REG_ADDR_WIDTH-1:0] dec_rs2_i,
  input  logic [`REG_ADDR_WIDTH-1:0] dec_rd_i,
  output logic                       hazard_o
);

  localparam int AW    = `REG_ADDR_WIDTH;
  localparam int DW    = `DATA_WIDTH;
  localparam int PTR_W = $clog2(LL_FIFO_DEPTH);
  localparam int CNT_W = $clog2(LL_FIFO_DEPTH) + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ll_entry_t;

  ll_entry_t        r_mem [LL_FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [STV_W-1:0] r_starve_cnt;
  logic             r_hold;

  ll_entry_t        w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_wb_live;
  logic             w_starve_hit;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(LL_FIFO_DEPTH));
  assign ll_ready_o = !w_full;
  assign wb_hold_o  = r_hold;
  assign w_head     = r_mem[r_rd_ptr];

  assign w_push    = ll_valid_i && !w_full;
  // A pipeline write to x0 is a free slot, so it never blocks the drain.
  assign w_wb_live = wb_we_i && (wb_rd_addr_i != '0);
  assign w_pop     = !w_empty && (r_hold || !w_wb_live);

  // NOTE: FIFO storage is deliberately not reset; the pointers and count define validity,
  // so stale data is never observed and the array maps cleanly onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: ll_rd_addr_i, data: ll_rd_data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Hold fires on the cycle the head has been denied STARVE_LIMIT times in a row.
  assign w_starve_hit = (r_starve_cnt == STV_W'(STARVE_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
      r_hold       <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (w_empty || w_pop) begin
        r_starve_cnt <= '0;
      end else if (w_starve_hit) begin
        r_starve_cnt <= '0;
        r_hold       <= 1'b1;
      end else begin
        r_starve_cnt <= r_starve_cnt + STV_W'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    rf_we_o      = 1'b0;
    rf_rd_addr_o = '0;
    rf_rd_data_o = '0;
    if (w_pop) begin
      rf_we_o      = (w_head.addr != '0);
      rf_rd_addr_o = w_head.addr;
      rf_rd_data_o = w_head.data;
    end else if (w_wb_live) begin
      rf_we_o      = 1'b1;
      rf_rd_addr_o = wb_rd_addr_i;
      rf_rd_data_o = wb_rd_data_i;
    end
  end

`ifdef RF_SCOREBOARD_EN
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_set;
  logic [NREG-1:0] w_busy_clr;

  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (issue_i) w_busy_set[issue_rd_i] = 1'b1;
    if (w_pop)   w_busy_clr[w_head.addr] = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy; x0 stays clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= ((r_busy & ~w_busy_clr) | w_busy_set) & ~NREG'(1);
  end

  assign hazard_o = r_busy[dec_rs1_i] | r_busy[dec_rs2_i] | r_busy[dec_rd_i];
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{issue_i, issue_rd_i, dec_rs1_i, dec_rs2_i, dec_rd_i};
  assign hazard_o    = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler (defaults LL_FIFO_DEPTH=2, STARVE_LIMIT=4);
// exercises the scoreboard only when RF_SCOREBOARD_EN is defined.
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [4:0]  wb_rd_addr_i = '0;
  logic [31:0] wb_rd_data_i = '0;
  logic        wb_hold_o;
  logic        ll_valid_i = 1'b0;
  logic        ll_ready_o;
  logic [4:0]  ll_rd_addr_i = '0;
  logic [31:0] ll_rd_data_i = '0;
  logic        rf_we_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_rd_data_o;
  logic        issue_i = 1'b0;
  logic [4:0]  issue_rd_i = '0;
  logic [4:0]  dec_rs1_i = '0;
  logic [4:0]  dec_rs2_i = '0;
  logic [4:0]  dec_rd_i = '0;
  logic        hazard_o;

  int n_pass = 0;
  int n_total = 0;

  rf_write_scheduler #(.LL_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we_i(wb_we_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
    .wb_hold_o(wb_hold_o),
    .ll_valid_i(ll_valid_i), .ll_ready_o(ll_ready_o),
    .ll_rd_addr_i(ll_rd_addr_i), .ll_rd_data_i(ll_rd_data_i),
    .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .hazard_o(hazard_o)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are then driven 1ns after the edge, outputs sampled 2ns after.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle(input int n);
    wb_we_i = 1'b0; ll_valid_i = 1'b0; issue_i = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    wb_we_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h1;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd10; ll_rd_data_i = 32'hAAAA_0010;
    tick();
    ll_rd_addr_i = 5'd11; ll_rd_data_i = 32'hAAAA_0011;
    tick();
    ll_valid_i = 1'b0; wb_we_i = 1'b0;
    settle();
    n_total++; if (ll_ready_o !== 1'b0) $display("FAIL reset_prefill_full: ll_ready_o got %b want 0", ll_ready_o); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (ll_ready_o !== 1'b1) $display("FAIL reset_ready: ll_ready_o got %b want 1", ll_ready_o); else n_pass++;
    n_total++; if (rf_we_o !== 1'b0) $display("FAIL reset_rf_we: rf_we_o got %b want 0", rf_we_o); else n_pass++;
    n_total++; if (wb_hold_o !== 1'b0) $display("FAIL reset_hold: wb_hold_o got %b want 0", wb_hold_o); else n_pass++;
    n_total++; if (hazard_o !== 1'b0) $display("FAIL reset_hazard: hazard_o got %b want 0", hazard_o); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); settle();
      n_total++;
      if (rf_we_o !== 1'b0 || ll_ready_o !== 1'b1)
        $display("FAIL reset_no_drain[%0d]: rf_we_o=%b ll_ready_o=%b want 0/1", i, rf_we_o, ll_ready_o);
      else n_pass++;
    end
  endtask

  task automatic test_idle_port();
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd5; ll_rd_data_i = 32'hDEAD_BEEF;
    tick();
    ll_valid_i = 1'b0;
    settle();
    n_total++;
    if ({rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd5, 32'hDEAD_BEEF})
      $display("FAIL idle_write: got we=%b addr=%0d data=%h want 1/5/deadbeef", rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    tick(); settle();
    n_total++; if (rf_we_o !== 1'b0) $display("FAIL idle_after_pop: rf_we_o got %b want 0", rf_we_o); else n_pass++;
  endtask

  task automatic test_contention();
    wb_we_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h0000_0033;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd7; ll_rd_data_i = 32'h0000_0077;
    tick();
    ll_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_total++;
      if ({wb_hold_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b0, 1'b1, 5'd3, 32'h33})
        $display("FAIL contend_denied[%0d]: hold=%b we=%b addr=%0d data=%h want 0/1/3/33", i, wb_hold_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o);
      else n_pass++;
      tick();
    end
    settle();
    n_total++;
    if ({wb_hold_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 1'b1, 5'd7, 32'h77})
      $display("FAIL contend_hold_write: hold=%b we=%b addr=%0d data=%h want 1/1/7/77", wb_hold_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    tick(); settle();
    n_total++;
    if ({wb_hold_o, rf_rd_addr_o} !== {1'b0, 5'd3})
      $display("FAIL contend_hold_pulse: hold=%b addr=%0d want 0/3", wb_hold_o, rf_rd_addr_o);
    else n_pass++;
    idle(2);
  endtask

  task automatic test_full_fifo();
    wb_we_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h0000_0033;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd12; ll_rd_data_i = 32'h0000_000C;
    tick();
    ll_rd_addr_i = 5'd13; ll_rd_data_i = 32'h0000_000D;
    tick();
    ll_rd_addr_i = 5'd14; ll_rd_data_i = 32'h0000_000E;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_total++;
      if ({ll_ready_o, wb_hold_o, rf_rd_addr_o} !== {1'b0, 1'b0, 5'd3})
        $display("FAIL full_blocked[%0d]: ready=%b hold=%b addr=%0d want 0/0/3", i, ll_ready_o, wb_hold_o, rf_rd_addr_o);
      else n_pass++;
      tick();
    end
    settle();
    n_total++;
    if ({ll_ready_o, wb_hold_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b0, 1'b1, 1'b1, 5'd12, 32'hC})
      $display("FAIL full_pop_refuses_push: ready=%b hold=%b we=%b addr=%0d data=%h want 0/1/1/12/c", ll_ready_o, wb_hold_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    tick(); settle();
    n_total++;
    if ({ll_ready_o, rf_rd_addr_o} !== {1'b1, 5'd3})
      $display("FAIL full_reopen: ready=%b addr=%0d want 1/3", ll_ready_o, rf_rd_addr_o);
    else n_pass++;
    tick();
    ll_valid_i = 1'b0; wb_we_i = 1'b0;
    settle();
    n_total++;
    if ({rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd13, 32'hD})
      $display("FAIL full_order_second: we=%b addr=%0d data=%h want 1/13/d", rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    tick(); settle();
    n_total++;
    if ({rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd14, 32'hE})
      $display("FAIL full_order_third: we=%b addr=%0d data=%h want 1/14/e", rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    tick(); settle();
    n_total++; if (rf_we_o !== 1'b0) $display("FAIL full_drained: rf_we_o got %b want 0", rf_we_o); else n_pass++;
  endtask

  task automatic test_x0_slot();
    wb_we_i = 1'b1; wb_rd_addr_i = 5'd3; wb_rd_data_i = 32'h33;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd9; ll_rd_data_i = 32'h0000_0999;
    tick();
    ll_valid_i = 1'b0; wb_rd_addr_i = 5'd0;
    settle();
    n_total++;
    if ({rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd9, 32'h999})
      $display("FAIL x0_slot_drain: we=%b addr=%0d data=%h want 1/9/999", rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    tick(); settle();
    n_total++; if (rf_we_o !== 1'b0) $display("FAIL x0_wb_suppressed: rf_we_o got %b want 0", rf_we_o); else n_pass++;
    wb_we_i = 1'b0;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd0; ll_rd_data_i = 32'h1234_5678;
    tick();
    ll_rd_addr_i = 5'd8; ll_rd_data_i = 32'h0000_0888;
    settle();
    n_total++; if (rf_we_o !== 1'b0) $display("FAIL x0_ll_no_write: rf_we_o got %b want 0", rf_we_o); else n_pass++;
    tick();
    ll_valid_i = 1'b0;
    settle();
    n_total++;
    if ({rf_we_o, rf_rd_addr_o, rf_rd_data_o} !== {1'b1, 5'd8, 32'h888})
      $display("FAIL x0_ll_popped: we=%b addr=%0d data=%h want 1/8/888", rf_we_o, rf_rd_addr_o, rf_rd_data_o);
    else n_pass++;
    idle(2);
  endtask

`ifdef RF_SCOREBOARD_EN
  task automatic test_scoreboard();
    dec_rs1_i = 5'd1; dec_rs2_i = 5'd4; dec_rd_i = 5'd2;
    issue_i = 1'b1; issue_rd_i = 5'd4;
    settle();
    n_total++; if (hazard_o !== 1'b0) $display("FAIL sb_before_issue: hazard_o got %b want 0", hazard_o); else n_pass++;
    tick();
    issue_i = 1'b0;
    settle();
    n_total++; if (hazard_o !== 1'b1) $display("FAIL sb_after_issue: hazard_o got %b want 1", hazard_o); else n_pass++;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd4; ll_rd_data_i = 32'h44;
    tick();
    ll_valid_i = 1'b0;
    settle();
    n_total++;
    if ({hazard_o, rf_we_o, rf_rd_addr_o} !== {1'b1, 1'b1, 5'd4})
      $display("FAIL sb_during_write: hazard=%b we=%b addr=%0d want 1/1/4", hazard_o, rf_we_o, rf_rd_addr_o);
    else n_pass++;
    tick(); settle();
    n_total++; if (hazard_o !== 1'b0) $display("FAIL sb_cleared: hazard_o got %b want 0", hazard_o); else n_pass++;
    issue_i = 1'b1; issue_rd_i = 5'd4;
    tick();
    issue_i = 1'b0;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd4; ll_rd_data_i = 32'h45;
    tick();
    ll_valid_i = 1'b0;
    issue_i = 1'b1; issue_rd_i = 5'd4;
    settle();
    n_total++; if (hazard_o !== 1'b1) $display("FAIL sb_reissue_pop_cycle: hazard_o got %b want 1", hazard_o); else n_pass++;
    tick();
    issue_i = 1'b0;
    settle();
    n_total++; if (hazard_o !== 1'b1) $display("FAIL sb_set_wins: hazard_o got %b want 1", hazard_o); else n_pass++;
    ll_valid_i = 1'b1; ll_rd_addr_i = 5'd4; ll_rd_data_i = 32'h46;
    tick();
    ll_valid_i = 1'b0;
    tick(); settle();
    n_total++; if (hazard_o !== 1'b0) $display("FAIL sb_final_clear: hazard_o got %b want 0", hazard_o); else n_pass++;
    issue_i = 1'b1; issue_rd_i = 5'd0;
    tick();
    issue_i = 1'b0; dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
    settle();
    n_total++; if (hazard_o !== 1'b0) $display("FAIL sb_x0_never_busy: hazard_o got %b want 0", hazard_o); else n_pass++;
  endtask
`else
  task automatic test_scoreboard();
    issue_i = 1'b1; issue_rd_i = 5'd4;
    dec_rs1_i = 5'd4; dec_rs2_i = 5'd4; dec_rd_i = 5'd4;
    tick();
    issue_i = 1'b0;
    settle();
    n_total++; if (hazard_o !== 1'b0) $display("FAIL sb_disabled: hazard_o got %b want 0", hazard_o); else n_pass++;
    dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
  endtask
`endif

  initial begin
    #12 rst_n = 1'b1;
    tick();
    test_reset();
    idle(2);
    test_idle_port();
    idle(2);
    test_contention();
    test_full_fifo();
    idle(2);
    test_x0_slot();
    test_scoreboard();
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Shares the register file's single synchronous write port between the in-order pipeline writeback and a long-latency execution unit (multiply/divide, miss-return load). Results from the long-latency unit are buffered in a small FIFO and drained into free write-port cycles, with a starvation guard that briefly holds writeback. An optional scoreboard tracks destinations with results still outstanding so decode can stall on RAW/WAW hazards. Sits between the writeback stage / long-latency unit and the register file write port.

## Interface
Parameters:
- LL_FIFO_DEPTH, 2: long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 4: consecutive denied cycles before writeback is held (≥1)

Ports (widths from common defines: `REG_ADDR_WIDTH`, `DATA_WIDTH`):
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- wb_we_i  in  1  pipeline writeback valid
- wb_rd_addr_i  in  REG_ADDR_WIDTH  pipeline destination
- wb_rd_data_i  in  DATA_WIDTH  pipeline result
- wb_hold_o  out  1  pipeline must not write back this cycle
- ll_valid_i  in  1  long-latency result valid
- ll_ready_o  out  1  FIFO can accept
- ll_rd_addr_i  in  REG_ADDR_WIDTH  long-latency destination
- ll_rd_data_i  in  DATA_WIDTH  long-latency result
- rf_we_o  out  1  register file write enable
- rf_rd_addr_o  out  REG_ADDR_WIDTH  register file write address
- rf_rd_data_o  out  DATA_WIDTH  register file write data
- issue_i  in  1  decode issues an instruction to the long-latency unit
- issue_rd_i  in  REG_ADDR_WIDTH  its destination
- dec_rs1_i, dec_rs2_i, dec_rd_i  in  REG_ADDR_WIDTH  decode operands to check
- hazard_o  out  1  decode must stall

## Operation
- FIFO accepts on ll_valid_i && ll_ready_o; ll_ready_o = !full (combinational from registered count).
- Write-port arbitration per cycle, priority order:
  1. wb_hold_o=1 and FIFO non-empty: FIFO head written; wb_we_i ignored (pipeline contract: must be 0).
  2. wb_we_i=1 and wb_rd_addr_i≠0: pipeline written; FIFO waits.
  3. otherwise FIFO non-empty: head written, popped.
  4. else rf_we_o=0.
- Pipeline write to x0 counts as a free slot (case 3). LL results to x0 are popped with rf_we_o=0.
- rf_* outputs are combinational muxes of wb inputs and registered FIFO head: zero added latency for pipeline writeback.
- Starvation counter: increments each cycle FIFO non-empty and not popped; clears on pop or empty. On reaching STARVE_LIMIT, wb_hold_o is registered high for exactly one cycle and counter clears.
- Simultaneous push and pop on a full FIFO: push refused (ready already low); push and pop on non-full: both occur, count unchanged.

## Timing
- Reset (async): FIFO empty, pointers/count 0, starvation counter 0, wb_hold_o=0, scoreboard cleared; thus ll_ready_o=1, rf_we_o=0 (with wb_we_i=0), hazard_o=0. Reset mid-drain discards buffered results.
- LL result accepted at edge N: earliest rf_we_o for it in cycle after edge N; register file captures it at edge N+1.
- Worst-case LL wait under continuous writeback: STARVE_LIMIT+1 cycles from becoming head.
- Pointers wrap modulo LL_FIFO_DEPTH; count width log2(depth)+1.

## Configuration
- RF_SCOREBOARD_EN defined: 32 busy bits. issue_i with issue_rd_i≠0 sets busy[issue_rd_i] at edge; LL pop for address A clears busy[A]; same-cycle set and clear of one register: set wins. hazard_o = busy[dec_rs1_i] | busy[dec_rs2_i] | busy[dec_rd_i] (combinational; x0 never busy).
- Undefined: no busy state, hazard_o tied 0, issue_* and dec_* unused.

## Test plan
- Reset: assert rst_n=0 mid-drain with 2 entries -> after release ll_ready_o=1, rf_we_o=0, hazard_o=0, no buffered write ever emitted.
- Idle port: LL push x5=0xDEADBEEF, wb_we_i=0 -> next cycle rf_we_o=1, rf_rd_addr_o=5, rf_rd_data_o=0xDEADBEEF.
- Contention: wb writes x3 every cycle, LL pushes x7 -> x7 waits STARVE_LIMIT=4 cycles, wb_hold_o pulses one cycle, x7 written in that cycle.
- Full FIFO: push 2 with wb busy -> ll_ready_o=0; third push held until pop, then accepted; order preserved.
- x0 slot: wb_we_i=1, wb_rd_addr_i=0 with FIFO head x9 -> x9 written same cycle.
- Scoreboard (RF_SCOREBOARD_EN): issue x4, decode rs2=x4 -> hazard_o=1 until cycle after LL x4 write; issue x4 again on pop cycle -> hazard_o stays 1.
